// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives all eight patterns of a 3-input gate under test, holds each for
//   SETTLE cycles, samples the gate output on the last cycle of each pattern
//   and compares it against the EXPECTED truth table (Wolfram order).
//
// Parameters
//   EXPECTED  bit 7-k is the expected output for index k = {in1,in2,in3}
//   SETTLE    cycles each pattern is held before sampling (1..255)
//
// Ports
//   clk       clock, rising edge
//   reset     asynchronous active-high reset
//   start     begin a sweep (sampled in idle only)
//   abort     synchronous cancel of a sweep in progress
//   dut_out   output of the gate under test
//   in1..in3  registered stimulus, in1 is the index MSB
//   busy      sweep in progress
//   done      one-cycle pulse at sweep completion
//   pass      last completed sweep had no mismatch
//   mismatch  bit k set when index k sampled wrong

module truth_table_sweeper #(
   parameter logic [7:0]  EXPECTED = 8'h61,
   parameter int unsigned SETTLE   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] mismatch
);

   typedef enum logic [1:0] {
      s_idle,
      s_drive,
      s_done
   } state_t;

   localparam logic [7:0] last_cnt = 8'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] stim_q, stim_d;
   logic [7:0] mm_q, mm_d;
   logic       pass_q, pass_d;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= s_idle;
         idx_q   <= 3'd0;
         cnt_q   <= 8'd0;
         stim_q  <= 3'd0;
         mm_q    <= 8'h00;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         stim_q  <= stim_d;
         mm_q    <= mm_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      mm_d    = mm_q;
      pass_d  = pass_q;
      unique case (state_q)
         s_idle: begin
            if (start) begin
               state_d = s_drive;
               idx_d   = 3'd0;
               cnt_d   = 8'd0;
               mm_d    = 8'h00;
               pass_d  = 1'b0;
            end
         end
         s_drive: begin
            // abort wins over a sample due on the same edge
            if (abort) begin
               state_d = s_idle;
               pass_d  = 1'b0;
            end else if (cnt_q == last_cnt) begin
               mm_d[idx_q] = dut_out ^ EXPECTED[3'd7 - idx_q];
               if (idx_q == 3'd7) begin
                  state_d = s_done;
                  // pass is valid in the same cycle as the done pulse
                  pass_d  = ~|mm_d;
               end else begin
                  idx_d = idx_q + 3'd1;
                  cnt_d = 8'd0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         s_done: begin
            state_d = s_idle;
         end
         default: begin
            state_d = s_idle;
         end
      endcase

      // stimulus is registered from the next state so it lines up with it
      unique case (state_d)
         s_drive: stim_d = idx_d;
         s_done:  stim_d = 3'b111;
         default: stim_d = 3'b000;
      endcase
   end

   // Outputs
   always_comb begin
      busy            = (state_q == s_drive);
      done            = (state_q == s_done);
      {in1, in2, in3} = stim_q;
      pass            = pass_q;
      mismatch        = mm_q;
   end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter EXPECTED, default 8'h61, the 3-input truth table in Wolfram order: bit 7-k is the expected output for input index k = {in1,in2,in3}.
REQ-002 The block SHALL have parameter SETTLE, default 4, legal range 1..255: cycles each input pattern is held before its sample is taken.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins a sweep when sampled high in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of a sweep in progress.
REQ-007 The block SHALL have port dut_out, input, 1 bit: output of the logic gate under test.
REQ-008 The block SHALL have ports in1, in2, in3, each output, 1 bit: registered stimulus to the gate under test; in1 is the MSB of the index.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 The block SHALL have port pass, output, 1 bit: high when the last completed sweep had no mismatch.
REQ-012 The block SHALL have port mismatch, output, 8 bits: bit k set when index k sampled wrong in the last or current sweep.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE and DONE, with internal registers idx[2:0] and cnt[7:0].
REQ-014 In IDLE, {in1,in2,in3} SHALL be 3'b000 and busy SHALL be 0.
REQ-015 IDLE with start=1 SHALL go to DRIVE, and on that same edge SHALL set idx=0, cnt=0, mismatch=0 and pass=0.
REQ-016 In DRIVE, {in1,in2,in3} SHALL equal idx and busy SHALL be 1.
REQ-017 In DRIVE with cnt<SETTLE-1, each edge SHALL increment cnt.
REQ-018 In DRIVE with cnt==SETTLE-1, the edge SHALL load mismatch[idx] with dut_out XOR EXPECTED[7-idx].
REQ-019 On that sampling edge, if idx<7 the block SHALL increment idx and clear cnt; if idx==7 it SHALL go to DONE.
REQ-020 Each pattern SHALL be held exactly SETTLE cycles, so a full sweep spends 8*SETTLE cycles in DRIVE.
REQ-021 With SETTLE=1 the block SHALL sample every cycle.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, pass SHALL be set to the NOR of the final mismatch including the index-7 result, and the next state SHALL be IDLE.
REQ-023 In DONE, the inputs SHALL remain at 3'b111.
REQ-024 start SHALL be ignored in DRIVE and DONE; a start held high through DONE SHALL begin a new sweep from the first IDLE cycle.
REQ-025 abort=1 in DRIVE SHALL return the block to IDLE on the next edge with no done pulse, pass=0, and mismatch holding the partial results.
REQ-026 abort SHALL take priority over the sampling edge in the same cycle.
REQ-027 abort SHALL have no effect in IDLE or DONE.
REQ-028 pass and mismatch SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-029 While reset=1, asynchronously and independent of clk, the block SHALL be in IDLE with idx=0, cnt=0, in1=in2=in3=0, busy=0, done=0, pass=0 and mismatch=8'h00.
REQ-030 A reset mid-sweep SHALL discard all partial results and generate no done pulse.
REQ-031 After reset deasserts, a new sweep SHALL require a fresh start sampled high.

Verification
REQ-032 Correct 0x61 gate model, SETTLE=4, start pulse -> busy for 32 cycles, done pulses once, pass=1, mismatch=8'h00, inputs step 000..111 every 4 cycles.
REQ-033 dut_out tied 0 -> done after 32 cycles, pass=0, mismatch=8'h86 (indices 1, 2 and 7).
REQ-034 Inverted gate model (~0x61) -> pass=0, mismatch=8'hFF; then a second sweep with the correct model -> mismatch cleared at start, final pass=1.
REQ-035 SETTLE=1, correct model -> done exactly 8 cycles after start is accepted; start pulsed at cycle 3 of the sweep is ignored.
REQ-036 Reset asserted asynchronously at idx=3 -> all outputs 0 immediately without a clock edge; abort at idx=5 -> IDLE next edge, no done, pass=0, mismatch retains bits from indices 0..4.
